// File: rtl/pcm_rxtx_pkg.sv
// Shared types, helper functions and default parameter values for pcm_rxtx_mc.
package pcm_rxtx_pkg;

  localparam int unsigned NUM_CH_DEF   = 2;
  localparam int unsigned RX_W_DEF     = 32;
  localparam int unsigned TX_W_DEF     = 16;
  localparam int unsigned RX_DEPTH_DEF = 1024;
  localparam int unsigned TX_DEPTH_DEF = 1024;
  localparam int unsigned PWM_RES_DEF  = 8;
  localparam int unsigned PWM_DIV_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    WRITE,
    DRAIN
  } state_e;

  // Number of set bits in a channel mask (up to 8 channels).
  function automatic int unsigned popcount8(input logic [7:0] m);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) n += 32'(m[i]);
    return n;
  endfunction

  // Two's complement sample of width tw -> top pw bits in offset binary.
  function automatic logic [31:0] offset_bin(input logic [31:0] v,
                                             input int unsigned tw,
                                             input int unsigned pw);
    return (v ^ (32'd1 << (tw - 1))) >> (tw - pw);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with sync clear and word count.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count update; clear beats push/pop, full push and empty pop are dropped.
  always_comb begin
    do_push  = push && !srst && (count_q != LW'(DEPTH));
    do_pop   = pop && !srst && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (srst) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + LW'(1);
        2'b01:   count_d = count_q - LW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign level = count_q;

endmodule

// File: rtl/pcm_rxtx_mc.sv
// Multi-channel PCM capture / PWM playback controller.
// Define PCM_RXTX_MC_LEVEL_EN to expose RX/TX FIFO word counts as ports.
module pcm_rxtx_mc
  import pcm_rxtx_pkg::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned RX_W     = RX_W_DEF,
  parameter int unsigned TX_W     = TX_W_DEF,
  parameter int unsigned RX_DEPTH = RX_DEPTH_DEF,
  parameter int unsigned TX_DEPTH = TX_DEPTH_DEF,
  parameter int unsigned PWM_RES  = PWM_RES_DEF,
  parameter int unsigned PWM_DIV  = PWM_DIV_DEF
) (
  input  logic                   CLK_I,
  input  logic                   RST_N_I,
  input  logic                   START_TRANSACTION_I,
  input  logic                   STOP_TRANSACTION_I,
  input  logic                   RNW_I,
  input  logic [NUM_CH-1:0]      CH_MASK_I,
  input  logic                   TX_FIFO_RST_I,
  input  logic [TX_W-1:0]        TX_FIFO_D_I,
  input  logic                   TX_FIFO_WR_EN_I,
  output logic                   TX_FIFO_EMPTY_O,
  output logic                   TX_FIFO_FULL_O,
  input  logic                   RX_FIFO_RST_I,
  output logic [RX_W-1:0]        RX_FIFO_D_O,
  input  logic                   RX_FIFO_RD_EN_I,
  output logic                   RX_FIFO_EMPTY_O,
  output logic                   RX_FIFO_FULL_O,
  input  logic [NUM_CH*RX_W-1:0] PCM_DATA_I,
  input  logic                   PCM_VALID_I,
  output logic                   RX_OVERFLOW_O,
  output logic                   TX_UNDERRUN_O,
  output logic                   BUSY_O,
  output logic                   PWM_AUDIO_O,
  output logic                   PWM_AUDIO_T
`ifdef PCM_RXTX_MC_LEVEL_EN
  ,
  output logic [$clog2(RX_DEPTH):0] RX_FIFO_LEVEL_O,
  output logic [$clog2(TX_DEPTH):0] TX_FIFO_LEVEL_O
`endif
);

  localparam int unsigned RX_LW = $clog2(RX_DEPTH) + 1;
  localparam int unsigned TX_LW = $clog2(TX_DEPTH) + 1;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam logic [PWM_RES-1:0] DUTY_MID = PWM_RES'(1) << (PWM_RES - 1);

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d;
  logic                     start_q, stop_q, rnw_q, rx_rd_q, tx_wr_q;
  logic [NUM_CH-1:0]        seq_mask_q, seq_mask_d;
  logic [NUM_CH*RX_W-1:0]   seq_data_q, seq_data_d;
  logic                     rx_ovf_q, rx_ovf_d, tx_udr_q, tx_udr_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic [PWM_RES-1:0]       step_q, step_d, duty_q, duty_d;
  logic                     pwm_t_q, pwm_t_d;

  logic                     rx_push, rx_pop, tx_push, tx_pop;
  logic [RX_W-1:0]          rx_word;
  logic [TX_W-1:0]          tx_head;
  logic [RX_LW-1:0]         rx_level;
  logic [TX_LW-1:0]         tx_level;
  logic                     tx_empty, seq_busy, found;
  logic [CH_W-1:0]          sel;
  logic                     period_start, period_end, tx_run_q, tx_run_d;
  int unsigned              need, free;

  assign rx_pop   = RX_FIFO_RD_EN_I & ~rx_rd_q;
  assign tx_push  = TX_FIFO_WR_EN_I & ~tx_wr_q;
  assign seq_busy = |seq_mask_q;
  assign tx_empty = (tx_level == '0);

  sync_fifo_fwft #(.WIDTH(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(CLK_I), .rst_n(RST_N_I), .srst(RX_FIFO_RST_I), .push(rx_push),
    .pop(rx_pop), .din(rx_word), .dout(RX_FIFO_D_O), .level(rx_level)
  );

  sync_fifo_fwft #(.WIDTH(TX_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(CLK_I), .rst_n(RST_N_I), .srst(TX_FIFO_RST_I), .push(tx_push),
    .pop(tx_pop), .din(TX_FIFO_D_I), .dout(tx_head), .level(tx_level)
  );

  // RX sequencer: accept whole frames only, then push one enabled channel per cycle.
  always_comb begin
    seq_mask_d = seq_mask_q;
    seq_data_d = seq_data_q;
    rx_ovf_d   = rx_ovf_q;
    rx_push    = 1'b0;
    sel        = '0;
    found      = 1'b0;
    need       = popcount8(8'(CH_MASK_I));
    free       = 32'(RX_LW'(RX_DEPTH) - rx_level);
    for (int c = 0; c < NUM_CH; c++) begin
      if (seq_mask_q[c] && !found) begin
        sel   = CH_W'(c);
        found = 1'b1;
      end
    end
    rx_word = seq_data_q[sel*RX_W +: RX_W];
    if (seq_busy) begin
      rx_push         = 1'b1;
      seq_mask_d[sel] = 1'b0;
    end
    if (state_q == READ && PCM_VALID_I) begin
      if (seq_busy) begin
        rx_ovf_d = 1'b1;
      end else if (need != 0) begin
        if (free >= need) begin
          seq_mask_d = CH_MASK_I;
          seq_data_d = PCM_DATA_I;
        end else begin
          rx_ovf_d = 1'b1;
        end
      end
    end
    if (RX_FIFO_RST_I) rx_ovf_d = 1'b0;
  end

  // Transaction FSM and PWM serializer.
  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    tx_udr_d     = tx_udr_q;
    tx_pop       = 1'b0;
    pwm_t_d      = 1'b0;
    div_d        = '0;
    step_d       = '0;
    period_start = (div_q == '0) && (step_q == '0);
    period_end   = (div_q == DIV_W'(PWM_DIV - 1)) && (step_q == '1);
    case (state_q)
      IDLE:  if (start_q) state_d = CHECK;
      CHECK: state_d = rnw_q ? READ : WRITE;
      READ:  if (stop_q && !seq_busy) state_d = IDLE;
      WRITE: begin
        if (period_start) begin
          if (tx_empty) begin
            duty_d   = DUTY_MID;
            tx_udr_d = 1'b1;
            state_d  = DRAIN;
          end else begin
            tx_pop = 1'b1;
            duty_d = PWM_RES'(offset_bin(32'(tx_head), TX_W, PWM_RES));
            if (tx_level == TX_LW'(1) && !tx_push) state_d = DRAIN;
          end
        end
        if (stop_q) state_d = DRAIN;
        pwm_t_d = (step_q < duty_d);
      end
      DRAIN: begin
        pwm_t_d = !period_start && (step_q < duty_q);
        if (period_start || period_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_run_d = (state_d == WRITE) || (state_d == DRAIN);
    if (tx_run_q && tx_run_d) begin
      if (div_q == DIV_W'(PWM_DIV - 1)) begin
        step_d = step_q + PWM_RES'(1);
      end else begin
        div_d  = div_q + DIV_W'(1);
        step_d = step_q;
      end
    end
    if (TX_FIFO_RST_I) tx_udr_d = 1'b0;
    busy_d = (state_d != IDLE);
  end

  // All control, sequencer and serializer registers.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rnw_q      <= 1'b0;
      rx_rd_q    <= 1'b0;
      tx_wr_q    <= 1'b0;
      seq_mask_q <= '0;
      seq_data_q <= '0;
      rx_ovf_q   <= 1'b0;
      tx_udr_q   <= 1'b0;
      div_q      <= '0;
      step_q     <= '0;
      duty_q     <= '0;
      pwm_t_q    <= 1'b0;
      tx_run_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      start_q    <= START_TRANSACTION_I;
      stop_q     <= STOP_TRANSACTION_I;
      rnw_q      <= RNW_I;
      rx_rd_q    <= RX_FIFO_RD_EN_I;
      tx_wr_q    <= TX_FIFO_WR_EN_I;
      seq_mask_q <= seq_mask_d;
      seq_data_q <= seq_data_d;
      rx_ovf_q   <= rx_ovf_d;
      tx_udr_q   <= tx_udr_d;
      div_q      <= div_d;
      step_q     <= step_d;
      duty_q     <= duty_d;
      pwm_t_q    <= pwm_t_d;
      tx_run_q   <= tx_run_d;
    end
  end

  assign RX_FIFO_EMPTY_O = (rx_level == '0);
  assign RX_FIFO_FULL_O  = (rx_level == RX_LW'(RX_DEPTH));
  assign TX_FIFO_EMPTY_O = tx_empty;
  assign TX_FIFO_FULL_O  = (tx_level == TX_LW'(TX_DEPTH));
  assign RX_OVERFLOW_O   = rx_ovf_q;
  assign TX_UNDERRUN_O   = tx_udr_q;
  assign BUSY_O          = busy_q;
  assign PWM_AUDIO_O     = 1'b0;
  assign PWM_AUDIO_T     = pwm_t_q;
`ifdef PCM_RXTX_MC_LEVEL_EN
  assign RX_FIFO_LEVEL_O = rx_level;
  assign TX_FIFO_LEVEL_O = tx_level;
`endif

endmodule

// File: tb/tb_pcm_rxtx_mc.sv
// Directed self-checking bench for pcm_rxtx_mc (2 channels, 8-deep FIFOs, 8-bit PWM, div 4).
module tb_pcm_rxtx_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, rnw = 1'b0;
  logic [1:0]  mask = 2'b00;
  logic        tx_rst = 1'b0, tx_wr = 1'b0, rx_rst = 1'b0, rx_rd = 1'b0, valid = 1'b0;
  logic [15:0] tx_d = '0;
  logic [63:0] pcm = '0;
  logic        tx_empty, tx_full, rx_empty, rx_full, ovf, udr, busy, audio_o, audio_t;
  logic [31:0] rx_d;
`ifdef PCM_RXTX_MC_LEVEL_EN
  logic [3:0]  rx_level, tx_level;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int hi;

  always #5 clk = ~clk;

  pcm_rxtx_mc #(
    .NUM_CH(2), .RX_W(32), .TX_W(16), .RX_DEPTH(8), .TX_DEPTH(8),
    .PWM_RES(8), .PWM_DIV(4)
  ) dut (
    .CLK_I(clk), .RST_N_I(rst_n),
    .START_TRANSACTION_I(start), .STOP_TRANSACTION_I(stop), .RNW_I(rnw),
    .CH_MASK_I(mask),
    .TX_FIFO_RST_I(tx_rst), .TX_FIFO_D_I(tx_d), .TX_FIFO_WR_EN_I(tx_wr),
    .TX_FIFO_EMPTY_O(tx_empty), .TX_FIFO_FULL_O(tx_full),
    .RX_FIFO_RST_I(rx_rst), .RX_FIFO_D_O(rx_d), .RX_FIFO_RD_EN_I(rx_rd),
    .RX_FIFO_EMPTY_O(rx_empty), .RX_FIFO_FULL_O(rx_full),
    .PCM_DATA_I(pcm), .PCM_VALID_I(valid),
    .RX_OVERFLOW_O(ovf), .TX_UNDERRUN_O(udr), .BUSY_O(busy),
    .PWM_AUDIO_O(audio_o), .PWM_AUDIO_T(audio_t)
`ifdef PCM_RXTX_MC_LEVEL_EN
    , .RX_FIFO_LEVEL_O(rx_level), .TX_FIFO_LEVEL_O(tx_level)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [1:0] m, input logic [31:0] c0, input logic [31:0] c1);
    mask  = m;
    pcm   = {c1, c0};
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    tick(1);
    rx_rd = 1'b0;
    tick(1);
  endtask

  task automatic push_tx(input logic [15:0] d);
    tx_d  = d;
    tx_wr = 1'b1;
    tick(1);
    tx_wr = 1'b0;
    tick(1);
  endtask

  task automatic start_txn(input logic r);
    rnw   = r;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  task automatic stop_txn();
    stop = 1'b1;
    tick(2);
    stop = 1'b0;
  endtask

  task automatic run_period(output int h);
    h = 0;
    for (int i = 0; i < 1024; i++) begin
      if (audio_t) h++;
      tick(1);
    end
  endtask

  initial begin
    tick(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pwm_t", 32'(audio_t), 32'd0);
    check("rst_pwm_o", 32'(audio_o), 32'd0);
    check("rst_rx_empty", 32'(rx_empty), 32'd1);
    check("rst_tx_empty", 32'(tx_empty), 32'd1);
    check("rst_rx_full", 32'(rx_full), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_rx_d", rx_d, 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_udr", 32'(udr), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Two-channel frame: A then B, first push one cycle after valid
    start_txn(1'b1);
    check("busy_read", 32'(busy), 32'd1);
    frame(2'b11, 32'hA, 32'hB);
    check("no_push_yet", 32'(rx_empty), 32'd1);
    tick(1);
    check("first_push", 32'(rx_empty), 32'd0);
    check("head_a", rx_d, 32'hA);
    tick(1);
    pop_rx();
    check("head_b", rx_d, 32'hB);
    pop_rx();
    check("drained_ab", 32'(rx_empty), 32'd1);

    // Mask 2'b10 over three frames: only channel 1 words
    frame(2'b10, 32'h0, 32'h11); tick(1);
    frame(2'b10, 32'h0, 32'h22); tick(1);
    frame(2'b10, 32'h0, 32'h33); tick(2);
    check("ch1_w0", rx_d, 32'h11); pop_rx();
    check("ch1_w1", rx_d, 32'h22); pop_rx();
    check("ch1_w2", rx_d, 32'h33); pop_rx();
    check("ch1_empty", 32'(rx_empty), 32'd1);
    check("ch1_no_ovf", 32'(ovf), 32'd0);

    // All-zero mask pushes nothing and raises no flag
    frame(2'b00, 32'h1, 32'h2); tick(2);
    check("mask0_empty", 32'(rx_empty), 32'd1);
    check("mask0_no_ovf", 32'(ovf), 32'd0);

    // Valid while sequencer busy drops the second frame
    frame(2'b11, 32'h1, 32'h2);
    frame(2'b11, 32'h3, 32'h4);
    tick(2);
    check("busy_drop_ovf", 32'(ovf), 32'd1);
    check("busy_drop_w0", rx_d, 32'h1); pop_rx();
    check("busy_drop_w1", rx_d, 32'h2); pop_rx();
    check("busy_drop_empty", 32'(rx_empty), 32'd1);
    rx_rst = 1'b1; tick(1); rx_rst = 1'b0;
    check("ovf_clr1", 32'(ovf), 32'd0);

    // Seven of eight words used: two-channel frame must be dropped whole
    for (int i = 0; i < 7; i++) begin
      frame(2'b01, 32'h100 + 32'(i), 32'h0);
      tick(1);
    end
    check("seven_not_full", 32'(rx_full), 32'd0);
    check("seven_no_ovf", 32'(ovf), 32'd0);
    frame(2'b11, 32'hAA, 32'hBB); tick(2);
    check("space_drop_ovf", 32'(ovf), 32'd1);
    check("space_drop_not_full", 32'(rx_full), 32'd0);
    check("space_drop_head", rx_d, 32'h100);
    frame(2'b01, 32'hCC, 32'h0); tick(1);
    check("level_was_seven", 32'(rx_full), 32'd1);
    tick(5);
    check("ovf_sticky", 32'(ovf), 32'd1);
    rx_rst = 1'b1; tick(1); rx_rst = 1'b0;
    check("rx_rst_empty", 32'(rx_empty), 32'd1);
    check("rx_rst_ovf", 32'(ovf), 32'd0);
    check("rx_rst_d", rx_d, 32'd0);
    stop_txn();
    check("read_stopped", 32'(busy), 32'd0);

    // Playback: 0x0000 -> 128, 0x7FFF -> 255, 0xFF00 -> 127 steps of 4 clocks
    push_tx(16'h0000);
    push_tx(16'h7FFF);
    push_tx(16'hFF00);
    check("tx_loaded", 32'(tx_empty), 32'd0);
    start_txn(1'b0);
    tick(1);
    run_period(hi); check("pwm_0000", 32'(hi), 32'd512);
    run_period(hi); check("pwm_7fff", 32'(hi), 32'd1020);
    run_period(hi); check("pwm_ff00", 32'(hi), 32'd508);
    check("drain_idle", 32'(busy), 32'd0);
    check("drain_pwm_low", 32'(audio_t), 32'd0);
    check("drain_no_udr", 32'(udr), 32'd0);
    check("drain_tx_empty", 32'(tx_empty), 32'd1);

    // Underrun: empty FIFO at first period start plays midscale then idles
    start_txn(1'b0);
    tick(1);
    check("udr_set", 32'(udr), 32'd1);
    check("udr_busy", 32'(busy), 32'd1);
    run_period(hi); check("pwm_mid", 32'(hi), 32'd512);
    check("udr_idle", 32'(busy), 32'd0);
    check("udr_sticky", 32'(udr), 32'd1);
    tx_rst = 1'b1; tick(1); tx_rst = 1'b0;
    check("udr_clr", 32'(udr), 32'd0);

    // Async reset mid-frame
    start_txn(1'b1);
    frame(2'b11, 32'h5, 32'h6);
    tick(1);
    check("pre_rst_rx", 32'(rx_empty), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_frame_busy", 32'(busy), 32'd0);
    check("mid_frame_empty", 32'(rx_empty), 32'd1);
    check("mid_frame_d", rx_d, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_rx_empty", 32'(rx_empty), 32'd1);

    // Async reset mid-period
    push_tx(16'h0000);
    push_tx(16'h0000);
    start_txn(1'b0);
    tick(100);
    check("pre_rst_pwm", 32'(audio_t), 32'd1);
    check("pre_rst_tx", 32'(tx_empty), 32'd0);
    #3 rst_n = 1'b0;
    #1;
    check("mid_period_pwm", 32'(audio_t), 32'd0);
    check("mid_period_busy", 32'(busy), 32'd0);
    check("mid_period_tx_empty", 32'(tx_empty), 32'd1);
    tick(1);
    rst_n = 1'b1;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
